// File: rtl/cache_arb_pkg.sv
// Shared types for the cache fill arbiter: FSM states, fill owner, block geometry.
// Latency: n/a (types only).  Backpressure: n/a.
package cache_arb_pkg;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
   typedef enum logic {OWN_I, OWN_D} owner_t;

   localparam int WORDS_DEFAULT = 8;

   // Clears the byte offset within a block of WORDS_DEFAULT 16-bit words.
   localparam logic [15:0] BLOCK_MASK_DEFAULT = ~16'(2 * WORDS_DEFAULT - 1);

endpackage

// File: rtl/word_counter.sv
// Synchronous up-counter with clear and increment enable.
// Latency: count updates on the next clk edge.  Backpressure: none.
module word_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr)
         count <= '0;
      else if (inc)
         count <= count + 1'b1;
   end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache misses and streams one block fill at a time from main memory; CACHE_ARB_RR_EN selects round-robin.
// Latency: grant in cycle T, requests T+1..T+WORDS, tag pulse one cycle after the last valid word.  Backpressure: stall_n freezes the pipeline.
module cache_fill_arbiter
   import cache_arb_pkg::*;
#(
   parameter int WORDS  = WORDS_DEFAULT,
   parameter int ADDR_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_miss,
   input  logic [ADDR_W-1:0]        i_miss_addr,
   input  logic                     d_miss,
   input  logic [ADDR_W-1:0]        d_miss_addr,
   input  logic [15:0]              mem_data_out,
   input  logic                     mem_data_valid,
   output logic                     mem_enable,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [15:0]              fill_data,
   output logic [$clog2(WORDS)-1:0] fill_word,
   output logic                     i_fill_we,
   output logic                     d_fill_we,
   output logic                     i_tag_we,
   output logic                     d_tag_we,
   output logic                     stall_n
);

   localparam int CW = $clog2(WORDS) + 1;
   localparam int LW = $clog2(WORDS);
   localparam logic [ADDR_W-1:0] BLK_MASK = ~ADDR_W'(2 * WORDS - 1);

   state_t            state, state_nxt;
   owner_t            owner;
   logic [ADDR_W-1:0] base;
   logic [CW-1:0]     ic, rc;
   logic              any_miss, grant_d, ic_inc, rc_inc, cnt_clr;

   assign any_miss = i_miss | d_miss;

`ifdef CACHE_ARB_RR_EN
   // rr_d set means D wins the next simultaneous miss.
   logic rr_d;

   assign grant_d = d_miss & (~i_miss | rr_d);

   always_ff @(posedge clk) begin
      if (rst)
         rr_d <= 1'b1;
      else if (state == IDLE && i_miss && d_miss)
         rr_d <= ~grant_d;
   end
`else
   assign grant_d = d_miss;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         base  <= '0;
         owner <= OWN_D;
      end else begin
         state <= state_nxt;
         if (state == IDLE && any_miss) begin
            base  <= (grant_d ? d_miss_addr : i_miss_addr) & BLK_MASK;
            owner <= grant_d ? OWN_D : OWN_I;
         end
      end
   end

   assign cnt_clr = (state == IDLE);
   assign ic_inc  = (state == FILL) && (ic < CW'(WORDS));
   assign rc_inc  = (state == FILL) && mem_data_valid;

   word_counter #(.W(CW)) u_issue_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (ic_inc),
      .count (ic)
   );

   word_counter #(.W(CW)) u_recv_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .inc   (rc_inc),
      .count (rc)
   );

   always_comb begin
      state_nxt  = state;
      mem_enable = 1'b0;
      mem_addr   = '0;
      i_fill_we  = 1'b0;
      d_fill_we  = 1'b0;
      i_tag_we   = 1'b0;
      d_tag_we   = 1'b0;
      case (state)
         IDLE: begin
            if (any_miss)
               state_nxt = FILL;
         end
         FILL: begin
            if (ic < CW'(WORDS)) begin
               mem_enable = 1'b1;
               mem_addr   = base + ADDR_W'({ic, 1'b0});
            end
            if (mem_data_valid) begin
               i_fill_we = (owner == OWN_I);
               d_fill_we = (owner == OWN_D);
               if (rc == CW'(WORDS - 1))
                  state_nxt = DONE;
            end
         end
         DONE: begin
            i_tag_we  = (owner == OWN_I);
            d_tag_we  = (owner == OWN_D);
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign fill_data = mem_data_out;
   assign fill_word = rc[LW-1:0];
   assign stall_n   = (state == IDLE) & ~i_miss & ~d_miss;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency (4-cycle) memory model.
module tb_cache_fill_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_miss, d_miss;
   logic [15:0] i_miss_addr, d_miss_addr;
   logic [15:0] mem_data_out;
   logic        mem_data_valid;
   logic        mem_enable;
   logic [15:0] mem_addr;
   logic [15:0] fill_data;
   logic [2:0]  fill_word;
   logic        i_fill_we, d_fill_we, i_tag_we, d_tag_we, stall_n;

   int passed = 0;
   int total  = 0;
   int fails  = 0;
   int cyc    = 0;

   // Memory model: a request seen in cycle k returns (addr ^ 16'h5A5A) in cycle k+4.
   logic        vq [4] = '{default: 1'b0};
   logic [15:0] aq [4] = '{default: 16'h0};
   logic        pipe_vld = 1'b0;
   logic [15:0] pipe_dat = 16'h0;
   logic        force_vld = 1'b0;

   assign mem_data_valid = pipe_vld | force_vld;
   assign mem_data_out   = pipe_vld ? pipe_dat : 16'hBEEF;

   always @(negedge clk) begin
      pipe_vld = vq[3];
      pipe_dat = aq[3] ^ 16'h5A5A;
      for (int i = 3; i > 0; i--) begin
         vq[i] = vq[i-1];
         aq[i] = aq[i-1];
      end
      vq[0] = mem_enable;
      aq[0] = mem_addr;
   end

   always #5 clk = ~clk;

   cache_fill_arbiter #(.WORDS(8), .ADDR_W(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_miss         (i_miss),
      .i_miss_addr    (i_miss_addr),
      .d_miss         (d_miss),
      .d_miss_addr    (d_miss_addr),
      .mem_data_out   (mem_data_out),
      .mem_data_valid (mem_data_valid),
      .mem_enable     (mem_enable),
      .mem_addr       (mem_addr),
      .fill_data      (fill_data),
      .fill_word      (fill_word),
      .i_fill_we      (i_fill_we),
      .d_fill_we      (d_fill_we),
      .i_tag_we       (i_tag_we),
      .d_tag_we       (d_tag_we),
      .stall_n        (stall_n)
   );

   task automatic step();
      @(negedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Called at the check point of grant cycle t0; returns at the check point of the DONE cycle.
   task automatic run_fill(input bit is_d, input logic [15:0] addr, input int t0,
                           input int drop_after, input string tag, output int tagc);
      logic [15:0] base;
      int nreq, nwr;
      base = addr & 16'hFFF0;
      nreq = 0;
      nwr  = 0;
      tagc = -1;
      #1;
      chk({tag, "_stall_grant"}, stall_n, 0);
      for (int k = 0; k < 60 && tagc < 0; k++) begin
         step();
         chk({tag, "_stall_busy"}, stall_n, 0);
         if (mem_enable) begin
            chk({tag, "_req_addr"}, mem_addr, base + 16'(2 * nreq));
            chk({tag, "_req_cyc"}, cyc, t0 + 1 + nreq);
            nreq++;
         end
         if (is_d ? d_fill_we : i_fill_we) begin
            chk({tag, "_fill_word"}, fill_word, nwr);
            chk({tag, "_fill_data"}, fill_data, (base + 16'(2 * nwr)) ^ 16'h5A5A);
            nwr++;
            if (nwr == drop_after) begin
               if (is_d) d_miss = 1'b0;
               else      i_miss = 1'b0;
            end
         end
         if (is_d ? i_fill_we : d_fill_we) chk({tag, "_other_fill_we"}, 1, 0);
         if (is_d ? i_tag_we : d_tag_we)   chk({tag, "_other_tag_we"}, 1, 0);
         if (is_d ? d_tag_we : i_tag_we)   tagc = cyc;
      end
      chk({tag, "_nreq"}, nreq, 8);
      chk({tag, "_nwr"}, nwr, 8);
      chk({tag, "_tag_cyc"}, tagc, t0 + 13);
   endtask

   initial begin
      int tc, c0, nwr, stray;
      rst = 1'b1; i_miss = 1'b0; d_miss = 1'b0;
      i_miss_addr = 16'h0; d_miss_addr = 16'h0;
      step(); step();
      chk("rst_mem_enable", mem_enable, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_fill_word", fill_word, 0);
      chk("rst_we", {i_fill_we, d_fill_we, i_tag_we, d_tag_we}, 0);
      chk("rst_stall_n", stall_n, 1);
      rst = 1'b0;
      step();

      // Basic D fill.
      d_miss_addr = 16'h1234; d_miss = 1'b1;
      run_fill(1'b1, 16'h1234, cyc, -1, "dfill", tc);
      d_miss = 1'b0;
      step();
      chk("dfill_stall_after", stall_n, 1);

      // Simultaneous misses; D keeps missing so the second grant shows the policy.
      step();
      i_miss_addr = 16'h2000; d_miss_addr = 16'h3456;
      i_miss = 1'b1; d_miss = 1'b1;
      run_fill(1'b1, 16'h3456, cyc, -1, "cont_d1", tc);
      d_miss_addr = 16'h4440;
`ifdef CACHE_ARB_RR_EN
      run_fill(1'b0, 16'h2000, tc + 1, -1, "cont_i", tc);
      i_miss = 1'b0;
      run_fill(1'b1, 16'h4440, tc + 1, -1, "cont_d2", tc);
      d_miss = 1'b0;
`else
      run_fill(1'b1, 16'h4440, tc + 1, -1, "cont_d2", tc);
      d_miss = 1'b0;
      run_fill(1'b0, 16'h2000, tc + 1, -1, "cont_i", tc);
      i_miss = 1'b0;
`endif
      step();
      chk("cont_stall_after", stall_n, 1);

      // Block at the top of the address space.
      i_miss_addr = 16'hFFFE; i_miss = 1'b1;
      run_fill(1'b0, 16'hFFFE, cyc, -1, "wrap", tc);
      i_miss = 1'b0;
      step();

      // Stray memory valid while idle.
      force_vld = 1'b1;
      #1;
      chk("idle_vld_fill_we", {i_fill_we, d_fill_we}, 0);
      chk("idle_vld_stall", stall_n, 1);
      force_vld = 1'b0;
      step();
      chk("idle_vld_stall_next", stall_n, 1);
      chk("idle_vld_mem_enable", mem_enable, 0);

      // Reset after three words land.
      d_miss_addr = 16'h0800; d_miss = 1'b1;
      nwr = 0;
      for (int k = 0; k < 40 && nwr < 3; k++) begin
         step();
         if (d_fill_we) nwr++;
      end
      chk("rst_mid_words", nwr, 3);
      rst = 1'b1; d_miss = 1'b0;
      step();
      chk("rst_mid_fill_we", {i_fill_we, d_fill_we}, 0);
      chk("rst_mid_tag_we", {i_tag_we, d_tag_we}, 0);
      chk("rst_mid_stall", stall_n, 1);
      rst = 1'b0;
      stray = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (i_fill_we | d_fill_we | i_tag_we | d_tag_we | mem_enable) stray++;
      end
      chk("rst_mid_stray", stray, 0);
      d_miss_addr = 16'h0900; d_miss = 1'b1;
      run_fill(1'b1, 16'h0900, cyc, -1, "restart", tc);
      d_miss = 1'b0;
      step();

      // Miss withdrawn part-way through the fill.
      c0 = cyc;
      d_miss_addr = 16'hABCD; d_miss = 1'b1;
      run_fill(1'b1, 16'hABCD, c0, 4, "drop", tc);
      chk("drop_miss_low", d_miss, 0);
      step();
      chk("drop_stall_after", stall_n, 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
